// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator sharing one prescaled time base.
// Configuration is double-buffered: upd_i captures the inputs into staging
// registers, and they become active only at a period boundary (or at once
// while disabled). A period boundary therefore never produces a glitch.
//
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   en_i             run the time base (0 = idle, outputs inactive)
//   upd_i            one-cycle request to load center_i/psc_i/period_i/duty_i/pol_i
//   center_i         0 = edge-aligned, 1 = centre-aligned counting
//   psc_i            counter advances every psc_i+1 clocks
//   period_i         counter top value
//   duty_i           per-channel duty, channel k at [k*CNT_W +: CNT_W]
//   pol_i            per-channel polarity, 1 = active-low
//   pwm_o            registered PWM outputs
//   cnt_o            current counter value
//   period_end_o     one-clock pulse after each period boundary
//   upd_ack_o        one-clock pulse after a configuration load
module pwm_gen_multi #(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned PSC_W  = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      en_i,
    input  logic                      upd_i,
    input  logic                      center_i,
    input  logic [PSC_W-1:0]          psc_i,
    input  logic [CNT_W-1:0]          period_i,
    input  logic [CH_NUM*CNT_W-1:0]   duty_i,
    input  logic [CH_NUM-1:0]         pol_i,
    output logic [CH_NUM-1:0]         pwm_o,
    output logic [CNT_W-1:0]          cnt_o,
    output logic                      period_end_o,
    output logic                      upd_ack_o
);

    logic [PSC_W-1:0]        psc_cnt_q, psc_cnt_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    dir_q, dir_d;           // 0 = up, 1 = down
    logic [PSC_W-1:0]        psc_act_q, psc_act_d, psc_stg_q, psc_stg_d;
    logic [CNT_W-1:0]        period_act_q, period_act_d, period_stg_q, period_stg_d;
    logic [CH_NUM*CNT_W-1:0] duty_act_q, duty_act_d, duty_stg_q, duty_stg_d;
    logic [CH_NUM-1:0]       pol_act_q, pol_act_d, pol_stg_q, pol_stg_d;
    logic                    center_act_q, center_act_d, center_stg_q, center_stg_d;
    logic                    pending_q, pending_d;
    logic [CH_NUM-1:0]       pwm_q, pwm_d;
    logic                    period_end_q, period_end_d;
    logic                    upd_ack_q, upd_ack_d;

    logic                    tick;
    logic                    boundary;
    logic                    load_in;
    logic                    load_stg;
    logic                    capture;
    logic [CH_NUM-1:0]       raw;

    always_comb begin
        psc_cnt_d    = psc_cnt_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        psc_act_d    = psc_act_q;
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        pol_act_d    = pol_act_q;
        center_act_d = center_act_q;
        psc_stg_d    = psc_stg_q;
        period_stg_d = period_stg_q;
        duty_stg_d   = duty_stg_q;
        pol_stg_d    = pol_stg_q;
        center_stg_d = center_stg_q;
        pending_d    = pending_q;
        pwm_d        = pwm_q;
        period_end_d = 1'b0;
        upd_ack_d    = 1'b0;
        load_in      = 1'b0;
        load_stg     = 1'b0;

        tick = en_i && (psc_cnt_q == psc_act_q);
        // A zero top value in centre mode makes every tick a boundary.
        if (center_act_q) begin
            boundary = tick && (cnt_q == '0) && (dir_q || (period_act_q == '0));
        end else begin
            boundary = tick && (cnt_q == period_act_q);
        end

        for (int k = 0; k < CH_NUM; k++) begin
            raw[k] = cnt_q < duty_act_q[k*CNT_W +: CNT_W];
        end

        if (!en_i) begin
            psc_cnt_d = '0;
            cnt_d     = '0;
            dir_d     = 1'b0;
            pwm_d     = pol_act_q;
            load_stg  = pending_q;
        end else begin
            pwm_d     = raw ^ pol_act_q;
            psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;
            if (tick) begin
                if (center_act_q) begin
                    if (period_act_q == '0) begin
                        cnt_d = '0;
                    end else if (!dir_q) begin
                        if (cnt_q == period_act_q) begin
                            cnt_d = cnt_q - 1'b1;
                            dir_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        if (cnt_q == '0) begin
                            cnt_d = cnt_q + 1'b1;
                            dir_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end else begin
                    cnt_d = (cnt_q == period_act_q) ? '0 : cnt_q + 1'b1;
                end
            end
            if (boundary) begin
                period_end_d = 1'b1;
                // A request coinciding with the boundary bypasses staging.
                load_in      = upd_i;
                load_stg     = pending_q && !upd_i;
            end
        end

        capture = upd_i && !load_in;

        if (load_in || load_stg) begin
            upd_ack_d = 1'b1;
            pending_d = 1'b0;
            cnt_d     = '0;
            dir_d     = 1'b0;
            psc_cnt_d = '0;
        end
        if (load_in) begin
            psc_act_d    = psc_i;
            period_act_d = period_i;
            duty_act_d   = duty_i;
            pol_act_d    = pol_i;
            center_act_d = center_i;
        end
        if (load_stg) begin
            psc_act_d    = psc_stg_q;
            period_act_d = period_stg_q;
            duty_act_d   = duty_stg_q;
            pol_act_d    = pol_stg_q;
            center_act_d = center_stg_q;
        end
        // Capture after the staged load so a disabled-state request re-arms pending.
        if (capture) begin
            psc_stg_d    = psc_i;
            period_stg_d = period_i;
            duty_stg_d   = duty_i;
            pol_stg_d    = pol_i;
            center_stg_d = center_i;
            pending_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            psc_cnt_q    <= '0;
            cnt_q        <= '0;
            dir_q        <= 1'b0;
            psc_act_q    <= '0;
            period_act_q <= '1;
            duty_act_q   <= '0;
            pol_act_q    <= '0;
            center_act_q <= 1'b0;
            psc_stg_q    <= '0;
            period_stg_q <= '0;
            duty_stg_q   <= '0;
            pol_stg_q    <= '0;
            center_stg_q <= 1'b0;
            pending_q    <= 1'b0;
            pwm_q        <= '0;
            period_end_q <= 1'b0;
            upd_ack_q    <= 1'b0;
        end else begin
            psc_cnt_q    <= psc_cnt_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            psc_act_q    <= psc_act_d;
            period_act_q <= period_act_d;
            duty_act_q   <= duty_act_d;
            pol_act_q    <= pol_act_d;
            center_act_q <= center_act_d;
            psc_stg_q    <= psc_stg_d;
            period_stg_q <= period_stg_d;
            duty_stg_q   <= duty_stg_d;
            pol_stg_q    <= pol_stg_d;
            center_stg_q <= center_stg_d;
            pending_q    <= pending_d;
            pwm_q        <= pwm_d;
            period_end_q <= period_end_d;
            upd_ack_q    <= upd_ack_d;
        end
    end

    assign pwm_o        = pwm_q;
    assign cnt_o        = cnt_q;
    assign period_end_o = period_end_q;
    assign upd_ack_o    = upd_ack_q;

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Bench for pwm_gen_multi: a time-based reference model (clocks since the
// period started, counter derived arithmetically) checked every cycle, plus
// directed literal checks of period lengths, duty counts and handshakes.
module tb_pwm_gen_multi;

    localparam int CH = 4;
    localparam int CW = 8;
    localparam int PW = 8;

    logic           clk_i = 1'b0;
    logic           rst_n = 1'b1;
    logic           en_i = 1'b0;
    logic           upd_i = 1'b0;
    logic           center_i = 1'b0;
    logic [PW-1:0]  psc_i = '0;
    logic [CW-1:0]  period_i = '0;
    logic [CH*CW-1:0] duty_i = '0;
    logic [CH-1:0]  pol_i = '0;
    logic [CH-1:0]  pwm_o;
    logic [CW-1:0]  cnt_o;
    logic           period_end_o;
    logic           upd_ack_o;

    int checks = 0;
    int errs   = 0;
    int m_len;
    int m_ack;
    int m_hi [CH];

    pwm_gen_multi #(.CH_NUM(CH), .CNT_W(CW), .PSC_W(PW)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n),
        .en_i        (en_i),
        .upd_i       (upd_i),
        .center_i    (center_i),
        .psc_i       (psc_i),
        .period_i    (period_i),
        .duty_i      (duty_i),
        .pol_i       (pol_i),
        .pwm_o       (pwm_o),
        .cnt_o       (cnt_o),
        .period_end_o(period_end_o),
        .upd_ack_o   (upd_ack_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        int          k;          // clocks since the current period run began
        logic [7:0]  per;
        logic [7:0]  psc;
        logic [31:0] duty;
        logic [3:0]  pol;
        logic        center;
        logic        pending;
        logic [7:0]  s_per;
        logic [7:0]  s_psc;
        logic [31:0] s_duty;
        logic [3:0]  s_pol;
        logic        s_center;
        logic [7:0]  exp_cnt;
        logic [3:0]  exp_pwm;
        logic        exp_pe;
        logic        exp_ack;
    } model_t;

    model_t m;

    // Counter value after n ticks of a run that started at 0.
    function automatic int f_cnt(input int n, input int p, input logic c);
        int r;
        if (!c) return n % (p + 1);
        if (p == 0) return 0;
        r = n % (2 * p);
        return (r <= p) ? r : 2 * p - r;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r = '0;
        r.per = 8'hff;
        return r;
    endfunction

    function automatic model_t model_next(input model_t s, input logic en, input logic upd,
                                          input logic c_in, input logic [7:0] psc_in,
                                          input logic [7:0] per_in, input logic [31:0] duty_in,
                                          input logic [3:0] pol_in);
        model_t r;
        int div, n, p, cur;
        logic tick, bnd, load;
        r = s;
        r.exp_pe = 1'b0;
        r.exp_ack = 1'b0;
        load = 1'b0;
        if (!en) begin
            r.exp_pwm = s.pol;
            r.k = 0;
            if (s.pending) begin
                r.per = s.s_per; r.psc = s.s_psc; r.duty = s.s_duty;
                r.pol = s.s_pol; r.center = s.s_center;
                r.pending = 1'b0; r.exp_ack = 1'b1;
            end
            if (upd) begin
                r.s_per = per_in; r.s_psc = psc_in; r.s_duty = duty_in;
                r.s_pol = pol_in; r.s_center = c_in; r.pending = 1'b1;
            end
        end else begin
            div = int'(s.psc) + 1;
            p = int'(s.per);
            n = s.k / div;
            tick = (s.k % div) == div - 1;
            cur = f_cnt(n, p, s.center);
            for (int ch = 0; ch < CH; ch++)
                r.exp_pwm[ch] = (cur < int'(s.duty[ch*8 +: 8])) ^ s.pol[ch];
            if (s.center) bnd = tick && (p == 0 || (n % (2 * p) == 0 && n > 0));
            else          bnd = tick && (n % (p + 1) == p);
            r.k = s.k + 1;
            if (bnd) begin
                r.exp_pe = 1'b1;
                if (upd) begin
                    r.per = per_in; r.psc = psc_in; r.duty = duty_in;
                    r.pol = pol_in; r.center = c_in; load = 1'b1;
                end else if (s.pending) begin
                    r.per = s.s_per; r.psc = s.s_psc; r.duty = s.s_duty;
                    r.pol = s.s_pol; r.center = s.s_center; load = 1'b1;
                end
                if (load) begin
                    r.k = 0; r.pending = 1'b0; r.exp_ack = 1'b1;
                end
            end else if (upd) begin
                r.s_per = per_in; r.s_psc = psc_in; r.s_duty = duty_in;
                r.s_pol = pol_in; r.s_center = c_in; r.pending = 1'b1;
            end
        end
        r.exp_cnt = 8'(f_cnt(r.k / (int'(r.psc) + 1), int'(r.per), r.center));
        return r;
    endfunction

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else m <= model_next(m, en_i, upd_i, center_i, psc_i, period_i, duty_i, pol_i);
    end

    always @(negedge clk_i) begin
        check("cnt_o", 32'(cnt_o), 32'(m.exp_cnt));
        check("pwm_o", 32'(pwm_o), 32'(m.exp_pwm));
        check("period_end_o", 32'(period_end_o), 32'(m.exp_pe));
        check("upd_ack_o", 32'(upd_ack_o), 32'(m.exp_ack));
    end

    // ---------------- directed helpers ----------------
    task automatic do_upd(input logic c, input logic [7:0] psc, input logic [7:0] per,
                          input logic [31:0] duty, input logic [3:0] pol);
        @(posedge clk_i); #1;
        center_i = c; psc_i = psc; period_i = per; duty_i = duty; pol_i = pol; upd_i = 1'b1;
        @(posedge clk_i); #1;
        upd_i = 1'b0;
    endtask

    task automatic wait_ack(input string name, input int budget);
        int g = 0;
        do begin @(negedge clk_i); g++; end while (!upd_ack_o && g < budget);
        check(name, 32'(upd_ack_o), 32'd1);
    endtask

    task automatic wait_pe(input string name);
        int g = 0;
        do begin @(negedge clk_i); g++; end while (!period_end_o && g < 3000);
        check(name, 32'(period_end_o), 32'd1);
    endtask

    // Length of the next full period between two period_end_o pulses.
    task automatic measure(input string name);
        wait_pe(name);
        m_len = 0; m_ack = 0;
        for (int ch = 0; ch < CH; ch++) m_hi[ch] = 0;
        do begin
            @(negedge clk_i);
            m_len++;
            if (upd_ack_o) m_ack++;
            for (int ch = 0; ch < CH; ch++) if (pwm_o[ch]) m_hi[ch]++;
        end while (!period_end_o && m_len < 3000);
    endtask

    int seq [10] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
    int acks;

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_cnt", 32'(cnt_o), 32'd0);
        check("rst_pwm", 32'(pwm_o), 32'd0);
        check("rst_pe", 32'(period_end_o), 32'd0);
        check("rst_ack", 32'(upd_ack_o), 32'd0);
        #20 rst_n = 1'b1;

        // 1: edge, P=9, psc=0
        @(posedge clk_i); #1 en_i = 1'b1;
        do_upd(1'b0, 8'd0, 8'd9, {8'd255, 8'd10, 8'd3, 8'd0}, 4'b0000);
        wait_ack("t1_ack", 600);
        measure("t1_pe");
        check("t1_len", 32'(m_len), 32'd10);
        check("t1_ch0", 32'(m_hi[0]), 32'd0);
        check("t1_ch1", 32'(m_hi[1]), 32'd3);
        check("t1_ch2", 32'(m_hi[2]), 32'd10);
        check("t1_ch3", 32'(m_hi[3]), 32'd10);

        // 2: psc=3
        do_upd(1'b0, 8'd3, 8'd9, {8'd255, 8'd10, 8'd3, 8'd0}, 4'b0000);
        wait_ack("t2_ack", 100);
        measure("t2_pe");
        check("t2_len", 32'(m_len), 32'd40);
        check("t2_ch1", 32'(m_hi[1]), 32'd12);

        // 3: centre, P=4
        do_upd(1'b1, 8'd0, 8'd4, {8'd0, 8'd0, 8'd2, 8'd0}, 4'b0000);
        wait_ack("t3_ack", 100);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk_i);
            check("t3_seq", 32'(cnt_o), 32'(seq[i]));
        end
        measure("t3_pe");
        check("t3_len", 32'(m_len), 32'd8);
        check("t3_ch1", 32'(m_hi[1]), 32'd3);

        // 4: two mid-period updates, only the latest loads, single ack
        do_upd(1'b0, 8'd0, 8'd9, {8'd255, 8'd10, 8'd3, 8'd0}, 4'b0000);
        wait_ack("t4_ack0", 100);
        wait_pe("t4_pe0");
        do_upd(1'b0, 8'd0, 8'd9, {8'd255, 8'd10, 8'd7, 8'd0}, 4'b0000);
        do_upd(1'b0, 8'd0, 8'd9, {8'd255, 8'd10, 8'd5, 8'd0}, 4'b0000);
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            if (upd_ack_o) begin
                acks++;
                check("t4_ack_at_pe", 32'(period_end_o), 32'd1);
            end
        end
        check("t4_single_ack", 32'(acks), 32'd1);
        measure("t4_pe");
        check("t4_ch1", 32'(m_hi[1]), 32'd5);

        // 5: polarity and disable
        do_upd(1'b0, 8'd0, 8'd9, {8'd255, 8'd10, 8'd3, 8'd0}, 4'b0010);
        wait_ack("t5_ack0", 100);
        @(posedge clk_i); #1 en_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        check("t5_idle_pwm", 32'(pwm_o), 32'h2);
        do_upd(1'b0, 8'd0, 8'd9, {8'd255, 8'd10, 8'd3, 8'd0}, 4'b0010);
        wait_ack("t5_dis_ack", 3);
        @(posedge clk_i); #1 en_i = 1'b1;
        @(negedge clk_i);
        check("t5_cnt0", 32'(cnt_o), 32'd0);
        @(negedge clk_i);
        check("t5_cnt1", 32'(cnt_o), 32'd1);

        // 6: async reset with an update pending
        wait_pe("t6_pe0");
        do_upd(1'b0, 8'd0, 8'd9, {8'd255, 8'd10, 8'd6, 8'd0}, 4'b0000);
        #1 rst_n = 1'b0;
        #1;
        check("t6_pwm", 32'(pwm_o), 32'd0);
        check("t6_cnt", 32'(cnt_o), 32'd0);
        @(posedge clk_i); #3 rst_n = 1'b1;
        measure("t6_pe");
        check("t6_len", 32'(m_len), 32'd256);
        check("t6_no_ack", 32'(m_ack), 32'd0);

        // Randomized operation against the model
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk_i); #1;
            if ($urandom_range(0, 79) == 0) en_i = ~en_i;
            upd_i = ($urandom_range(0, 19) == 0);
            if (upd_i) begin
                center_i = 1'($urandom_range(0, 1));
                psc_i    = 8'($urandom_range(0, 3));
                period_i = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
                for (int ch = 0; ch < CH; ch++) duty_i[ch*8 +: 8] = 8'($urandom_range(0, 15));
                pol_i    = 4'($urandom_range(0, 15));
            end
        end
        @(posedge clk_i); #1 upd_i = 1'b0;
        @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
